mbe_rad4_mult_pipe: RTL and testbench

//  Parametrised, pipelined radix-4 modified-Booth multiplier for FPU mantissa datapaths.

---
 rtl/mbe_rad4_mult_pipe_if.sv | 18 +
 rtl/mbe_rad4_mult_pipe.sv | 140 ++++++++++++++
 tb/tb_mbe_rad4_mult_pipe.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mbe_rad4_mult_pipe_if.sv
// Operand/product bundle for the radix-4 Booth multiplier pipeline.
// Both sides are valid/ready: a beat moves on any cycle where valid && ready are both high.
interface mbe_rad4_mult_pipe_if #(parameter int WIDTH = 11);
    logic               in_valid;
    logic               in_ready;
    logic               in_signed;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    modport master (output in_valid, in_signed, a, b, out_ready,
                    input  in_ready, out_valid, product, busy);
    modport slave  (input  in_valid, in_signed, a, b, out_ready,
                    output in_ready, out_valid, product, busy);
endinterface

// File: rtl/mbe_rad4_mult_pipe.sv
// Pipelined radix-4 modified-Booth multiplier (signed/unsigned) with an elastic
// valid/ready pipeline of PIPE_STAGES register slots.
module mbe_rad4_mult_pipe #(
    parameter int WIDTH       = 11,
    parameter int PIPE_STAGES = 3
) (
    input  logic                clk,
    input  logic                rst,
    mbe_rad4_mult_pipe_if.slave bus
);
    localparam int P  = 2 * WIDTH;
    localparam int NG = WIDTH / 2 + 1;
    localparam int NR = NG + 1;   // NG partial products plus one row carrying the neg bits

    typedef logic [NR-1:0][P-1:0] pp_t;
    typedef logic [1:0][P-1:0]    rows_t;

    function automatic pp_t pp_gen(input logic [WIDTH-1:0] op_a,
                                   input logic [WIDTH-1:0] op_b,
                                   input logic             sgn);
        logic [WIDTH+1:0] a_ext;
        logic [2*NG:0]    bb;
        logic [2:0]       grp;
        logic [WIDTH+1:0] sel;
        logic             neg;
        pp_t              pp;
        a_ext = {{2{sgn & op_a[WIDTH-1]}}, op_a};
        // Low zero bit stands in for b[-1]; the top is extended so every group is full.
        bb    = {{(2*NG-WIDTH){sgn & op_b[WIDTH-1]}}, op_b, 1'b0};
        pp    = '0;
        for (int i = 0; i < NG; i++) begin
            grp = bb[2*i +: 3];
            neg = grp[2] & ~(grp[1] & grp[0]);
            case (grp)
                3'b001, 3'b010, 3'b101, 3'b110: sel = a_ext;
                3'b011, 3'b100:                 sel = a_ext << 1;
                default:                        sel = '0;
            endcase
            if (neg) sel = ~sel;
            pp[i]         = {{(P-WIDTH-2){sel[WIDTH+1]}}, sel} << (2*i);
            pp[NR-1][2*i] = neg;
        end
        return pp;
    endfunction

    // Wallace-style layers of 3:2 compressors until two rows remain.
    function automatic rows_t reduce(input pp_t pp);
        logic [P-1:0] cur [NR+2];
        logic [P-1:0] nxt [NR+2];
        int           n;
        int           m;
        for (int k = 0; k < NR + 2; k++) begin
            cur[k] = (k < NR) ? pp[k] : '0;
            nxt[k] = '0;
        end
        n = NR;
        for (int l = 0; l < NR; l++) begin
            if (n > 2) begin
                m = 0;
                for (int k = 0; k < NR + 2; k++) nxt[k] = '0;
                for (int g = 0; g < NR; g += 3) begin
                    if (g + 2 < n) begin
                        nxt[m]   = cur[g] ^ cur[g+1] ^ cur[g+2];
                        nxt[m+1] = ((cur[g] & cur[g+1]) | (cur[g] & cur[g+2]) |
                                    (cur[g+1] & cur[g+2])) << 1;
                        m += 2;
                    end else if (g + 1 < n) begin
                        nxt[m]   = cur[g];
                        nxt[m+1] = cur[g+1];
                        m += 2;
                    end else if (g < n) begin
                        nxt[m] = cur[g];
                        m += 1;
                    end
                end
                cur = nxt;
                n   = m;
            end
        end
        return {cur[1], cur[0]};
    endfunction

    logic [PIPE_STAGES-1:0] v;
    logic [PIPE_STAGES-1:0] adv;
    logic [PIPE_STAGES-1:0] load;
    logic                   free0;
    logic [P-1:0]           prod_q;

    // A stage advances when it holds data and the slot after it is empty or moving.
    always_comb begin
        logic f;
        adv  = '0;
        load = '0;
        f    = bus.out_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            adv[k] = v[k] & f;
            f      = ~v[k] | (v[k] & f);
        end
        free0   = f;
        load[0] = bus.in_valid & free0;
        for (int k = 1; k < PIPE_STAGES; k++) load[k] = adv[k-1];
    end

    always_ff @(posedge clk) begin
        if (rst) v <= '0;
        else     v <= (v & ~adv) | load;
    end

    generate
        if (PIPE_STAGES == 3) begin : g_three
            pp_t   pp_q;
            rows_t rows_q;
            always_ff @(posedge clk) begin
                if (load[0]) pp_q <= pp_gen(bus.a, bus.b, bus.in_signed);
                if (load[1]) rows_q <= reduce(pp_q);
                if (rst)          prod_q <= '0;
                else if (load[2]) prod_q <= rows_q[0] + rows_q[1];
            end
        end else if (PIPE_STAGES == 2) begin : g_two
            rows_t rows_q;
            always_ff @(posedge clk) begin
                if (load[0]) rows_q <= reduce(pp_gen(bus.a, bus.b, bus.in_signed));
                if (rst)          prod_q <= '0;
                else if (load[1]) prod_q <= rows_q[0] + rows_q[1];
            end
        end else begin : g_one
            rows_t rows_c;
            assign rows_c = reduce(pp_gen(bus.a, bus.b, bus.in_signed));
            always_ff @(posedge clk) begin
                if (rst)          prod_q <= '0;
                else if (load[0]) prod_q <= rows_c[0] + rows_c[1];
            end
        end
    endgenerate

    assign bus.in_ready  = free0;
    assign bus.out_valid = v[PIPE_STAGES-1];
    assign bus.product   = prod_q;
    assign bus.busy      = |v;
endmodule

// File: tb/tb_mbe_rad4_mult_pipe.sv
// Directed and scoreboarded checks of the Booth multiplier pipeline at
// WIDTH 11 (PIPE_STAGES 1..3) and WIDTH 24 (PIPE_STAGES 3).
module tb_mbe_rad4_mult_pipe;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mbe_rad4_mult_pipe_if #(.WIDTH(11)) if1 ();
    mbe_rad4_mult_pipe_if #(.WIDTH(11)) if2 ();
    mbe_rad4_mult_pipe_if #(.WIDTH(11)) if3 ();
    mbe_rad4_mult_pipe_if #(.WIDTH(24)) if24 ();

    mbe_rad4_mult_pipe #(.WIDTH(11), .PIPE_STAGES(1)) u1  (.clk(clk), .rst(rst), .bus(if1.slave));
    mbe_rad4_mult_pipe #(.WIDTH(11), .PIPE_STAGES(2)) u2  (.clk(clk), .rst(rst), .bus(if2.slave));
    mbe_rad4_mult_pipe #(.WIDTH(11), .PIPE_STAGES(3)) u3  (.clk(clk), .rst(rst), .bus(if3.slave));
    mbe_rad4_mult_pipe #(.WIDTH(24), .PIPE_STAGES(3)) u24 (.clk(clk), .rst(rst), .bus(if24.slave));

    logic [21:0] exp_q1[$];
    logic [21:0] exp_q2[$];
    logic [21:0] exp_q3[$];

    function automatic logic [21:0] golden11(input logic [10:0] x, input logic [10:0] y,
                                             input logic s);
        logic [21:0] xe;
        logic [21:0] ye;
        xe = s ? {{11{x[10]}}, x} : {11'b0, x};
        ye = s ? {{11{y[10]}}, y} : {11'b0, y};
        return xe * ye;
    endfunction

    function automatic logic [10:0] pick11();
        case ($urandom_range(0, 7))
            0:       return 11'h000;
            1:       return 11'h400;
            2:       return 11'h7FF;
            default: return 11'($urandom_range(0, 2047));
        endcase
    endfunction

    task automatic idle_all();
        if1.in_valid = 0; if1.in_signed = 0; if1.a = '0; if1.b = '0; if1.out_ready = 1;
        if2.in_valid = 0; if2.in_signed = 0; if2.a = '0; if2.b = '0; if2.out_ready = 1;
        if3.in_valid = 0; if3.in_signed = 0; if3.a = '0; if3.b = '0; if3.out_ready = 1;
        if24.in_valid = 0; if24.in_signed = 0; if24.a = '0; if24.b = '0; if24.out_ready = 1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1;
        idle_all();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", if3.out_valid); end
        checks++; if (if3.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if3.busy); end
        checks++; if (if3.product !== 22'h0) begin errors++; $display("FAIL reset_product: got %h expected 0", if3.product); end
        checks++; if (if3.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", if3.in_ready); end
        checks++; if (if24.product !== 48'h0) begin errors++; $display("FAIL reset_product24: got %h expected 0", if24.product); end
        checks++; if (if24.busy !== 1'b0) begin errors++; $display("FAIL reset_busy24: got %b expected 0", if24.busy); end
        checks++; if (if1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_s1: got %b expected 0", if1.out_valid); end
        checks++; if (if2.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_s2: got %b expected 1", if2.in_ready); end
    endtask

    task automatic test_unsigned_latency();
        @(negedge clk);
        if3.in_valid = 1; if3.in_signed = 0; if3.a = 11'h7FF; if3.b = 11'h7FF; if3.out_ready = 1;
        #1;
        checks++; if (if3.in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: got %b expected 1", if3.in_ready); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if3.in_valid = 0;
            #1;
            checks++;
            if (if3.out_valid !== (c == 3)) begin
                errors++; $display("FAIL lat_out_valid_c%0d: got %b expected %b", c, if3.out_valid, c == 3);
            end
        end
        checks++; if (if3.product !== 22'h3FF001) begin errors++; $display("FAIL lat_product: got %h expected 3ff001", if3.product); end
        @(negedge clk);
        #1;
        checks++; if (if3.busy !== 1'b0) begin errors++; $display("FAIL lat_busy_after: got %b expected 0", if3.busy); end
    endtask

    task automatic test_back_to_back();
        logic        s_t [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [10:0] a_t [6] = '{11'h400, 11'h400, 11'h3FF, 11'h7FF, 11'h400, 11'h000};
        logic [10:0] b_t [6] = '{11'h7FF, 11'h400, 11'h400, 11'h7FF, 11'h7FF, 11'h7FF};
        logic [21:0] e_t [6] = '{22'h000400, 22'h100000, 22'h300400, 22'h000001, 22'h1FFC00, 22'h000000};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if3.out_ready = 1;
            if (c < 6) begin
                if3.in_valid = 1; if3.in_signed = s_t[c]; if3.a = a_t[c]; if3.b = b_t[c];
            end else begin
                if3.in_valid = 0;
            end
            #1;
            checks++;
            if (if3.out_valid !== (c >= 3 && c < 9)) begin
                errors++; $display("FAIL b2b_out_valid_c%0d: got %b expected %b", c, if3.out_valid, (c >= 3 && c < 9));
            end
            if (c >= 3 && c < 9) begin
                checks++;
                if (if3.product !== e_t[c-3]) begin
                    errors++; $display("FAIL b2b_product_%0d: got %h expected %h", c - 3, if3.product, e_t[c-3]);
                end
            end
        end
    endtask

    task automatic test_width24();
        logic        s_t [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [23:0] a_t [4] = '{24'hFFFFFF, 24'h800000, 24'hFFFFFF, 24'h7FFFFF};
        logic [23:0] b_t [4] = '{24'hFFFFFF, 24'h800000, 24'h000001, 24'h800000};
        logic [47:0] e_t [4] = '{48'hFFFFFE000001, 48'h400000000000, 48'hFFFFFFFFFFFF, 48'hC00000800000};
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if24.out_ready = 1;
            if (c < 4) begin
                if24.in_valid = 1; if24.in_signed = s_t[c]; if24.a = a_t[c]; if24.b = b_t[c];
            end else begin
                if24.in_valid = 0;
            end
            #1;
            if (c >= 3 && c < 7) begin
                checks++;
                if (if24.out_valid !== 1'b1 || if24.product !== e_t[c-3]) begin
                    errors++; $display("FAIL w24_product_%0d: got v=%b %h expected v=1 %h", c - 3, if24.out_valid, if24.product, e_t[c-3]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] va [8];
        logic [10:0] vb [8];
        logic [21:0] ve [8];
        int idx;
        int got;
        int gaps;
        for (int k = 0; k < 8; k++) begin
            va[k] = 11'(k + 5);
            vb[k] = 11'(12'h7F0 + k);
            ve[k] = 22'(va[k]) * 22'(vb[k]);
        end
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if3.out_ready = 0;
            if3.in_valid = 1; if3.in_signed = 0; if3.a = va[idx]; if3.b = vb[idx];
            #1;
            if (if3.in_ready) idx++;
        end
        checks++; if (idx !== 3) begin errors++; $display("FAIL bp_accepted: got %0d expected 3", idx); end
        @(negedge clk);
        #1;
        checks++; if (if3.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready: got %b expected 0", if3.in_ready); end
        checks++; if (if3.out_valid !== 1'b1 || if3.product !== ve[0]) begin
            errors++; $display("FAIL bp_hold: got v=%b %h expected v=1 %h", if3.out_valid, if3.product, ve[0]);
        end
        got  = 0;
        gaps = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(negedge clk);
            if3.out_ready = 1;
            if3.in_valid  = (idx < 8);
            if (idx < 8) begin if3.a = va[idx]; if3.b = vb[idx]; end
            #1;
            if (c == 0) begin
                checks++;
                if (if3.in_ready !== 1'b1) begin errors++; $display("FAIL bp_drain_accept: got %b expected 1", if3.in_ready); end
            end
            if (if3.out_valid) begin
                checks++;
                if (if3.product !== ve[got]) begin
                    errors++; $display("FAIL bp_order_%0d: got %h expected %h", got, if3.product, ve[got]);
                end
                got++;
            end else begin
                gaps++;
            end
            if (if3.in_valid && if3.in_ready) idx++;
        end
        checks++; if (got !== 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", got); end
        checks++; if (gaps !== 0) begin errors++; $display("FAIL bp_gaps: got %0d expected 0", gaps); end
        @(negedge clk);
        if3.in_valid = 0;
        #1;
        checks++; if (if3.busy !== 1'b0) begin errors++; $display("FAIL bp_busy_end: got %b expected 0", if3.busy); end
    endtask

    task automatic test_reset_midstream();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if3.out_ready = 1;
            if3.in_valid = 1; if3.in_signed = 1; if3.a = 11'(c + 1); if3.b = 11'h002;
        end
        @(negedge clk);
        rst = 1;
        if3.in_valid = 1; if3.a = 11'h005; if3.b = 11'h005;
        @(negedge clk);
        rst = 0;
        if3.in_valid = 0;
        #1;
        checks++; if (if3.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", if3.out_valid); end
        checks++; if (if3.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", if3.busy); end
        checks++; if (if3.product !== 22'h0) begin errors++; $display("FAIL mid_product: got %h expected 0", if3.product); end
        @(negedge clk);
        if3.in_valid = 1; if3.in_signed = 1; if3.a = 11'h400; if3.b = 11'h001;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if3.in_valid = 0;
            #1;
            checks++;
            if (if3.out_valid !== (c == 3)) begin
                errors++; $display("FAIL mid_new_valid_c%0d: got %b expected %b", c, if3.out_valid, c == 3);
            end
        end
        checks++; if (if3.product !== 22'h3FFC00) begin errors++; $display("FAIL mid_new_product: got %h expected 3ffc00", if3.product); end
    endtask

    task automatic test_random();
        int          n_ops;
        int          sent;
        int          got1;
        int          got2;
        int          got3;
        logic        orr;
        logic        iv;
        logic        s;
        logic [10:0] ra;
        logic [10:0] rb;
        logic [21:0] e;
        n_ops = 3000;
        sent = 0; got1 = 0; got2 = 0; got3 = 0;
        for (int cyc = 0; cyc < 30000 && (got1 < n_ops || got2 < n_ops || got3 < n_ops); cyc++) begin
            @(negedge clk);
            orr = ($urandom_range(0, 3) != 0);
            if1.out_ready = orr; if2.out_ready = orr; if3.out_ready = orr;
            #1;
            iv = (sent < n_ops) && ($urandom_range(0, 3) != 0) &&
                 if1.in_ready && if2.in_ready && if3.in_ready;
            s  = 1'($urandom_range(0, 1));
            ra = pick11();
            rb = pick11();
            if1.in_valid = iv; if1.in_signed = s; if1.a = ra; if1.b = rb;
            if2.in_valid = iv; if2.in_signed = s; if2.a = ra; if2.b = rb;
            if3.in_valid = iv; if3.in_signed = s; if3.a = ra; if3.b = rb;
            #1;
            if (iv) begin
                e = golden11(ra, rb, s);
                exp_q1.push_back(e); exp_q2.push_back(e); exp_q3.push_back(e);
                sent++;
            end
            if (if1.out_valid && if1.out_ready) begin
                checks++;
                if (exp_q1.size() == 0) begin errors++; $display("FAIL rand_s1_extra: got %h expected none", if1.product); end
                else begin
                    e = exp_q1.pop_front();
                    if (if1.product !== e) begin errors++; $display("FAIL rand_s1_%0d: got %h expected %h", got1, if1.product, e); end
                end
                got1++;
            end
            if (if2.out_valid && if2.out_ready) begin
                checks++;
                if (exp_q2.size() == 0) begin errors++; $display("FAIL rand_s2_extra: got %h expected none", if2.product); end
                else begin
                    e = exp_q2.pop_front();
                    if (if2.product !== e) begin errors++; $display("FAIL rand_s2_%0d: got %h expected %h", got2, if2.product, e); end
                end
                got2++;
            end
            if (if3.out_valid && if3.out_ready) begin
                checks++;
                if (exp_q3.size() == 0) begin errors++; $display("FAIL rand_s3_extra: got %h expected none", if3.product); end
                else begin
                    e = exp_q3.pop_front();
                    if (if3.product !== e) begin errors++; $display("FAIL rand_s3_%0d: got %h expected %h", got3, if3.product, e); end
                end
                got3++;
            end
        end
        checks++; if (got1 != n_ops) begin errors++; $display("FAIL rand_s1_count: got %0d expected %0d", got1, n_ops); end
        checks++; if (got2 != n_ops) begin errors++; $display("FAIL rand_s2_count: got %0d expected %0d", got2, n_ops); end
        checks++; if (got3 != n_ops) begin errors++; $display("FAIL rand_s3_count: got %0d expected %0d", got3, n_ops); end
        idle_all();
    endtask

    initial begin
        rst = 1;
        idle_all();
        test_reset();
        test_unsigned_latency();
        test_back_to_back();
        test_width24();
        test_backpressure();
        test_reset_midstream();
        apply_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
